// File: rtl/strobe_sequencer_if.sv
// Config handshake between the register block and strobe_sequencer.
// The register block drives the offer; the sequencer answers with cfg_ready.
interface strobe_sequencer_if #(
    parameter int WIDTH   = 16,
    parameter int BURST_W = 8
);
    logic               cfg_valid;
    logic               cfg_ready;
    logic [WIDTH-1:0]   cfg_period;
    logic [BURST_W-1:0] cfg_count;

    modport master (
        output cfg_valid,
        output cfg_period,
        output cfg_count,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_period,
        input  cfg_count,
        output cfg_ready
    );
endinterface

// File: rtl/strobe_sequencer.sv
// Sequences one counter_with_strobe: latches period/burst config, arms the counter,
// paces its enable against ready, counts strobes and signals burst completion.
module strobe_sequencer #(
    parameter int WIDTH   = 16,
    parameter int BURST_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    strobe_sequencer_if.slave  cfg,
    input  logic               start,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic               tick_out,
    output logic [BURST_W-1:0] remaining,
    output logic               cnt_rst,
    output logic               cnt_enable,
    output logic [WIDTH-1:0]   cnt_reset_value,
    input  logic               cnt_ready,
    input  logic               cnt_strobe
);

    typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} state_t;

    state_t             state;
    logic [WIDTH-1:0]   period_act;
    logic [BURST_W-1:0] count_act;
    logic               cont_act;
    logic               run_cont;
    logic               sh_full;
    logic [WIDTH-1:0]   sh_period;
    logic [BURST_W-1:0] sh_count;
    logic               sh_cont;
    logic               abort_rst;

    logic               in_run;
    logic               accept_idle;
    logic               accept_shadow;
    logic               abort_hit;
    logic               commit;
    logic [WIDTH-1:0]   period_clamped;

    // A period below 2 would leave the counter without a ready window.
    function automatic logic [WIDTH-1:0] clamp_period(input logic [WIDTH-1:0] p);
        return (p < WIDTH'(2)) ? WIDTH'(2) : p;
    endfunction

    assign in_run         = (state == RUN);
    assign busy           = (state == ARM) || in_run;
    assign done           = (state == DONE);
    assign cfg.cfg_ready  = (state == IDLE) || (busy && !sh_full);
    assign accept_idle    = (state == IDLE) && cfg.cfg_valid;
    assign accept_shadow  = busy && cfg.cfg_valid && !sh_full;
    assign abort_hit      = busy && abort;
    assign period_clamped = clamp_period(cfg.cfg_period);

    // Enable follows ready in RUN; ready drops after an enable, so a strobe cycle
    // always has enable low and is the safe moment to swap reset_value.
    assign cnt_enable = in_run && cnt_ready && !abort;
    assign cnt_rst    = rst || (state == ARM) || abort_rst;
    assign commit     = sh_full && ((in_run && cnt_strobe) || abort_hit || done);

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            period_act      <= WIDTH'(2);
            count_act       <= '0;
            cont_act        <= 1'b1;
            run_cont        <= 1'b0;
            sh_full         <= 1'b0;
            abort_rst       <= 1'b0;
            remaining       <= '0;
            tick_out        <= 1'b0;
            cnt_reset_value <= WIDTH'(2);
        end else begin
            tick_out  <= cnt_strobe && busy;
            abort_rst <= abort_hit;

            if (accept_idle) begin
                period_act      <= period_clamped;
                count_act       <= cfg.cfg_count;
                cont_act        <= (cfg.cfg_count == '0);
                cnt_reset_value <= period_clamped;
            end

            if (accept_shadow) begin
                sh_full   <= 1'b1;
                sh_period <= period_clamped;
                sh_count  <= cfg.cfg_count;
                sh_cont   <= (cfg.cfg_count == '0);
            end

            // Shadow count/mode land in the active set but only matter at the next ARM.
            if (commit) begin
                sh_full         <= 1'b0;
                period_act      <= sh_period;
                count_act       <= sh_count;
                cont_act        <= sh_cont;
                cnt_reset_value <= sh_period;
            end

            case (state)
                IDLE: begin
                    if (start) state <= ARM;
                end
                ARM: begin
                    if (abort) begin
                        state <= IDLE;
                    end else begin
                        remaining <= count_act;
                        run_cont  <= cont_act;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (cnt_strobe && !run_cont) begin
                        remaining <= remaining - BURST_W'(1);
                        if (remaining == BURST_W'(1)) state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_strobe_sequencer.sv
// Randomized bench for strobe_sequencer with a behavioural counter_with_strobe
// stand-in and burst-level expectations derived from the period/count rules.
module tb_strobe_sequencer;
    localparam int WIDTH   = 16;
    localparam int BURST_W = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               abort;
    logic               busy;
    logic               done;
    logic               tick_out;
    logic [BURST_W-1:0] remaining;
    logic               cnt_rst;
    logic               cnt_enable;
    logic [WIDTH-1:0]   cnt_reset_value;
    logic               cnt_ready;
    logic               cnt_strobe;

    int n_checks = 0;
    int n_errors = 0;

    strobe_sequencer_if #(.WIDTH(WIDTH), .BURST_W(BURST_W)) cfg_if ();

    strobe_sequencer #(.WIDTH(WIDTH), .BURST_W(BURST_W)) dut (
        .clk             (clk),
        .rst             (rst),
        .cfg             (cfg_if),
        .start           (start),
        .abort           (abort),
        .busy            (busy),
        .done            (done),
        .tick_out        (tick_out),
        .remaining       (remaining),
        .cnt_rst         (cnt_rst),
        .cnt_enable      (cnt_enable),
        .cnt_reset_value (cnt_reset_value),
        .cnt_ready       (cnt_ready),
        .cnt_strobe      (cnt_strobe)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Counter stand-in: enable loads reset_value, ready drops, a strobe fires
    // reset_value cycles later with ready still low, ready returns the cycle after.
    int c_cnt;
    always @(posedge clk) begin
        if (cnt_rst) begin
            cnt_ready  <= 1'b1;
            cnt_strobe <= 1'b0;
            c_cnt      <= 0;
        end else begin
            cnt_strobe <= 1'b0;
            if (cnt_enable) begin
                cnt_ready <= 1'b0;
                c_cnt     <= int'(cnt_reset_value) - 1;
            end else if (!cnt_ready) begin
                if (c_cnt > 1) c_cnt <= c_cnt - 1;
                else if (c_cnt == 1) begin
                    cnt_strobe <= 1'b1;
                    c_cnt      <= 0;
                end else cnt_ready <= 1'b1;
            end
        end
    end

    // Counter input rules watched on every cycle.
    logic             prev_busy = 1'b0;
    logic             prev_strobe = 1'b0;
    logic [WIDTH-1:0] prev_rv = '0;
    always @(negedge clk) begin
        if (cnt_enable) check_val("enable_needs_ready", cnt_ready, 1);
        if (!rst && busy && prev_busy && cnt_reset_value != prev_rv)
            check_val("rv_change_on_strobe", prev_strobe, 1);
        prev_busy   <= busy;
        prev_strobe <= cnt_strobe;
        prev_rv     <= cnt_reset_value;
    end

    function automatic int exp_period(input int p);
        return (p < 2) ? 2 : p;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_idle(input int p, input int c);
        cfg_if.cfg_valid  = 1'b1;
        cfg_if.cfg_period = WIDTH'(p);
        cfg_if.cfg_count  = BURST_W'(c);
        check_val("cfg_ready_idle", cfg_if.cfg_ready, 1);
        tick();
        cfg_if.cfg_valid = 1'b0;
        check_val("cfg_period_clamp", cnt_reset_value, exp_period(p));
    endtask

    task automatic start_burst();
        start = 1'b1;
        tick();
        start = 1'b0;
        check_val("arm_busy", busy, 1);
        check_val("arm_cnt_rst", cnt_rst, 1);
        check_val("arm_no_enable", cnt_enable, 0);
    endtask

    // Runs from the current cycle until the burst of `total` strobes completes.
    task automatic run_until_done(input int total, input int already);
        int n;
        bit s;
        bit fin;
        n   = already;
        fin = 1'b0;
        for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
            s = cnt_strobe;
            tick();
            if (cyc == 0 && already == 0) check_val("cnt_rst_one_cycle", cnt_rst, 0);
            check_val("tick_follows_strobe", tick_out, s);
            if (s) begin
                n++;
                if (n < total) begin
                    check_val("remaining", remaining, total - n);
                    check_val("busy_mid", busy, 1);
                end else begin
                    check_val("done_after_last", done, 1);
                    check_val("busy_with_done", busy, 0);
                    check_val("remaining_end", remaining, 0);
                    fin = 1'b1;
                end
            end else begin
                check_val("no_early_done", done, 0);
            end
        end
        if (!fin) check_val("burst_timeout", 0, 1);
        tick();
        check_val("done_one_pulse", done, 0);
        check_val("idle_after_done", busy, 0);
        check_val("cfg_ready_after", cfg_if.cfg_ready, 1);
    endtask

    initial begin
        int p, c, c2, seen;
        bit s;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        cfg_if.cfg_valid = 1'b0; cfg_if.cfg_period = '0; cfg_if.cfg_count = '0;
        repeat (3) tick();
        check_val("rst_cnt_rst", cnt_rst, 1);
        rst = 1'b0;
        tick();
        check_val("reset_busy", busy, 0);
        check_val("reset_done", done, 0);
        check_val("reset_tick", tick_out, 0);
        check_val("reset_remaining", remaining, 0);
        check_val("reset_rv", cnt_reset_value, 2);
        check_val("reset_cfg_ready", cfg_if.cfg_ready, 1);
        check_val("reset_enable", cnt_enable, 0);
        check_val("reset_cnt_rst", cnt_rst, 0);

        // Finite bursts with random period (including clamped values) and count.
        for (int k = 0; k < 4; k++) begin
            p = (k == 0) ? 3 : int'($urandom_range(0, 12));
            c = (k == 0) ? 2 : int'($urandom_range(1, 5));
            cfg_idle(p, c);
            start_burst();
            check_val("arm_rv", cnt_reset_value, exp_period(p));
            run_until_done(c, 0);
        end

        // Continuous mode never completes; leave it with abort.
        cfg_idle(0, 0);
        start_burst();
        seen = 0;
        for (int cyc = 0; cyc < 400 && seen < 6; cyc++) begin
            s = cnt_strobe;
            tick();
            check_val("cont_tick", tick_out, s);
            check_val("cont_no_done", done, 0);
            check_val("cont_remaining", remaining, 0);
            if (s) seen++;
        end
        check_val("cont_strobes", seen, 6);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_val("abort_busy", busy, 0);
        check_val("abort_cnt_rst", cnt_rst, 1);
        check_val("abort_no_done", done, 0);
        tick();
        check_val("abort_cnt_rst_once", cnt_rst, 0);

        // Config offered during RUN goes through the shadow.
        cfg_idle(5, 3);
        start_burst();
        c2 = int'($urandom_range(1, 4));
        cfg_if.cfg_valid  = 1'b1;
        cfg_if.cfg_period = WIDTH'(9);
        cfg_if.cfg_count  = BURST_W'($urandom_range(1, 5));
        check_val("shadow_free", cfg_if.cfg_ready, 1);
        tick();
        cfg_if.cfg_period = WIDTH'(7);
        cfg_if.cfg_count  = BURST_W'(c2);
        check_val("shadow_stall", cfg_if.cfg_ready, 0);
        seen = 0;
        for (int cyc = 0; cyc < 200 && seen == 0; cyc++) begin
            s = cnt_strobe;
            if (!s) begin
                check_val("rv_hold", cnt_reset_value, 5);
                check_val("stall_hold", cfg_if.cfg_ready, 0);
            end
            tick();
            if (s) begin
                seen = 1;
                check_val("rv_swap_on_strobe", cnt_reset_value, 9);
                check_val("shadow_released", cfg_if.cfg_ready, 1);
            end
        end
        check_val("shadow_strobe_seen", seen, 1);
        tick();
        cfg_if.cfg_valid = 1'b0;
        check_val("second_offer_held", cfg_if.cfg_ready, 0);
        run_until_done(3, 1);
        check_val("second_period_applied", cnt_reset_value, 7);
        start_burst();
        run_until_done(c2, 0);

        // Abort after one strobe, then a full burst.
        p = int'($urandom_range(2, 6));
        cfg_idle(p, 4);
        start_burst();
        seen = 0;
        for (int cyc = 0; cyc < 200 && seen == 0; cyc++) begin
            s = cnt_strobe;
            tick();
            if (s) seen = 1;
        end
        check_val("abort_mid_remaining", remaining, 3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_val("abort_mid_busy", busy, 0);
        check_val("abort_mid_cnt_rst", cnt_rst, 1);
        check_val("abort_mid_no_done", done, 0);
        tick();
        check_val("abort_mid_done_quiet", done, 0);
        start_burst();
        run_until_done(4, 0);

        // Abort landing on a strobe cycle.
        cfg_idle(3, 4);
        start_burst();
        for (int cyc = 0; cyc < 200 && !cnt_strobe; cyc++) tick();
        check_val("strobe_reached", cnt_strobe, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_val("abort_strobe_tick", tick_out, 1);
        check_val("abort_strobe_remaining", remaining, 4);
        check_val("abort_strobe_busy", busy, 0);
        check_val("abort_strobe_no_done", done, 0);
        tick();

        // Config and start in the same cycle.
        cfg_if.cfg_valid  = 1'b1;
        cfg_if.cfg_period = WIDTH'(4);
        cfg_if.cfg_count  = BURST_W'(1);
        start_burst();
        cfg_if.cfg_valid = 1'b0;
        check_val("bypass_rv", cnt_reset_value, 4);
        run_until_done(1, 0);

        // Reset during RUN with a pending shadow.
        cfg_idle(6, 5);
        start_burst();
        repeat (3) tick();
        cfg_if.cfg_valid  = 1'b1;
        cfg_if.cfg_period = WIDTH'(11);
        tick();
        cfg_if.cfg_valid = 1'b0;
        rst = 1'b1;
        tick();
        check_val("rst_run_busy", busy, 0);
        check_val("rst_run_done", done, 0);
        check_val("rst_run_tick", tick_out, 0);
        check_val("rst_run_remaining", remaining, 0);
        check_val("rst_run_cnt_rst", cnt_rst, 1);
        check_val("rst_run_enable", cnt_enable, 0);
        check_val("rst_run_rv", cnt_reset_value, 2);
        check_val("rst_run_cfg_ready", cfg_if.cfg_ready, 1);
        rst = 1'b0;
        repeat (8) tick();
        check_val("shadow_dropped", cnt_reset_value, 2);
        check_val("rst_idle_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/strobe_sequencer.md
Name: strobe_sequencer

Overview:
- Controller that sequences one `counter_with_strobe` instance.
- Latches a period and a burst count through a valid/ready config port, arms the counter and paces its `enable` input against the counter's `ready`.
- Counts the strobes it gets back and raises `done` after the requested number, or runs forever in continuous mode.
- Sits between a software/register block and the counter. It guarantees the counter's input rules: `enable` only when `ready`, and `reset_value` changes only on a strobe cycle with `enable` low.

Parameters:
- WIDTH, 16, width of the period / counter `reset_value`.
- BURST_W, 8, width of the burst (strobe) count.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- cfg_valid  in  1  config offer.
- cfg_ready  out  1  config accept.
- cfg_period  in  WIDTH  strobe period for the counter `reset_value`.
- cfg_count  in  BURST_W  strobes per burst; 0 = continuous.
- start  in  1  one-cycle request to begin a burst.
- abort  in  1  one-cycle request to stop immediately.
- busy  out  1  high in ARM/RUN.
- done  out  1  one-cycle pulse when a burst completes.
- tick_out  out  1  registered copy of cnt_strobe, gated by busy.
- remaining  out  BURST_W  strobes left in the current burst.
- cnt_rst  out  1  reset to the counter.
- cnt_enable  out  1  enable to the counter.
- cnt_reset_value  out  WIDTH  `reset_value` to the counter.
- cnt_ready  in  1  counter ready.
- cnt_strobe  in  1  counter strobe.

Behaviour:
- Reset values:
  - State IDLE.
  - cfg_ready=1, busy=0, done=0, tick_out=0, remaining=0.
  - cnt_rst=1 while rst is high; cnt_enable=0.
  - cnt_reset_value=2.
  - Shadow config empty.
- Period clamp: a cfg_period below 2 is stored as 2.
- IDLE:
  - cfg_ready=1. A handshake (cfg_valid&&cfg_ready) writes period, count and continuous flag (count==0) directly into the active registers; cnt_reset_value updates the next cycle.
  - start → ARM. If cfg_valid and start arrive in the same cycle, the new config is used for this burst (bypass).
  - abort is ignored.
- ARM (exactly 1 cycle): cnt_rst=1, remaining<=count, busy=1 → RUN.
- RUN:
  - cnt_enable = cnt_ready & !abort (combinational). This gives one enable per counter ready window, so enable is never high while ready is low.
  - On cnt_strobe: tick_out=1 the next cycle.
  - If not continuous, remaining decrements; when remaining==1 at the strobe → DONE.
  - Continuous mode: remaining holds 0 and never completes.
- DONE (1 cycle): done=1, busy=0 → IDLE. The counter is left as-is, no cnt_rst.
- Config during RUN:
  - cfg_ready = !shadow_full.
  - An accepted config goes to the shadow.
  - On the next cnt_strobe cycle (cnt_enable is 0 then, since cnt_ready is low after an enable), the shadow period is copied to cnt_reset_value and the shadow is cleared.
  - The shadow count/mode take effect only at the next start. If the shadow is still full on exit to IDLE, it is committed to the active registers.
  - cnt_reset_value never changes in RUN except on a strobe cycle.
- abort in ARM/RUN:
  - → IDLE next cycle, with cnt_rst=1 for that cycle, cnt_enable=0, busy=0, no done.
  - If abort and cnt_strobe coincide, tick_out still pulses, remaining is not decremented, and abort wins.
- start while busy: ignored.
- rst in any state: returns to the reset values next cycle; the shadow is discarded.

Test Plan:
- Config period=3, count=2, then start → ARM pulses cnt_rst once; exactly 2 tick_out pulses; done pulses once, 1 cycle after the 2nd strobe; busy falls with done; cnt_enable never high while cnt_ready is low.
- Config period=0 → cnt_reset_value reads 2 (clamp); count=0 with start → tick_out repeats indefinitely, done never asserts, remaining stays 0.
- In RUN with period=5, offer period=9 → cfg_ready drops until the next strobe; cnt_reset_value changes to 9 only in a cnt_strobe cycle; a second offer is stalled until then.
- abort mid-burst (count=4, after 1 strobe) → busy=0 next cycle, cnt_rst pulses 1 cycle, no done, a later start runs a full 4-strobe burst.
- cfg_valid(period=4,count=1) and start in the same IDLE cycle → burst uses period 4, one tick_out, then done.
- rst asserted during RUN → all outputs at reset values the next cycle, shadow dropped, cfg_ready=1.
